instr_fetch: RTL and testbench

Instruction fetch stage directly downstream of the program-counter stage. Takes the current PC, issues in-order read requests to instruction memory over a valid/ready request channel, and tracks up to DEPTH requests, with each response paired with its PC. Returns instruction/PC pairs to decode over a valid/ready channel. Handles redirects (flush) by dropping queued entries and discarding stale in-flight responses, and tells the PC stage when to advance.

---
 rtl/instr_fetch.sv | 120 ++++++++++++
 tb/tb_instr_fetch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues in-order imem reads for pc_i, pairs each
// response with its PC in a DEPTH-slot queue and hands pairs to decode.
module instr_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  flush,
  output logic                  pc_advance,
  output logic                  imem_req_valid,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      filled_q, filled_d;
  logic [PW-1:0]         alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
  logic [CW-1:0]         count_q, count_d;
  // inflight_q: current-path requests accepted but not yet answered
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [CW-1:0]         discard_q, discard_d;
  logic [CW-1:0]         stale_total;
  logic                  issue, fill, pop;

  // Issue gating uses registered occupancy only, so memory/decode handshakes never reach req_valid
  assign imem_req_valid = !rst && !flush && (({1'b0, count_q} + {1'b0, discard_q}) < DEPTH_C);
  assign imem_req_addr  = pc_i;
  assign pc_advance     = imem_req_valid && imem_req_ready;
  assign instr_valid    = !rst && !flush && filled_q[head_q];
  assign instr_data     = data_q[head_q];
  assign instr_pc       = pc_q[head_q];

  assign issue       = pc_advance;
  assign pop         = instr_valid && instr_ready;
  assign fill        = imem_rsp_valid && !flush && (discard_q == CW'(0));
  assign stale_total = discard_q + inflight_q;

  always_comb begin
    filled_d   = filled_q;
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    head_d     = head_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    if (flush) begin
      filled_d   = '0;
      alloc_d    = '0;
      fill_d     = '0;
      head_d     = '0;
      count_d    = '0;
      inflight_d = '0;
      if (imem_rsp_valid && (stale_total != CW'(0))) begin
        discard_d = stale_total - CW'(1);
      end else begin
        discard_d = stale_total;
      end
    end else begin
      if (issue) begin
        filled_d[alloc_q] = 1'b0;
        alloc_d           = alloc_q + PW'(1);
      end
      if (imem_rsp_valid && (discard_q != CW'(0))) begin
        discard_d = discard_q - CW'(1);
      end else if (fill) begin
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + PW'(1);
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PW'(1);
      end
      count_d    = count_q + CW'(issue) - CW'(pop);
      inflight_d = inflight_q + CW'(issue) - CW'(fill);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filled_q   <= '0;
      alloc_q    <= '0;
      fill_q     <= '0;
      head_q     <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      filled_q   <= filled_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      head_q     <= head_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      if (issue) begin
        pc_q[alloc_q] <= pc_i;
      end
      if (fill) begin
        data_q[fill_q] <= imem_rsp_data;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: PC-stage and memory models drive the DUT,
// a scoreboard queue pairs accepted requests with instructions seen at decode.
module tb_instr_fetch;
  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        flush;
  logic        pc_advance;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] start_pc = 32'h0;
  logic [31:0] target = 32'h0;
  logic        rst_seen = 1'b1;
  logic        fl_seen = 1'b0;
  logic        adv_seen = 1'b0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] expq[$];

  instr_fetch dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .flush(flush), .pc_advance(pc_advance),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // PC stage + fixed-latency memory; records accepted requests into the scoreboard
  initial begin
    pc_i = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_seen) pc_i = start_pc;
      else if (fl_seen) pc_i = target;
      else if (adv_seen) pc_i = pc_i + 32'd4;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = 32'h0;
      if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = memfn(mq_addr[0]);
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      #3;
      rst_seen = rst;
      fl_seen = flush;
      adv_seen = pc_advance;
      if (rst) begin
        mq_addr.delete();
        mq_due.delete();
        expq.delete();
      end else begin
        if (flush) expq.delete();
        if (imem_req_valid && imem_req_ready) begin
          chk("req_addr_eq_pc", imem_req_addr, pc_i);
          mq_addr.push_back(imem_req_addr);
          mq_due.push_back(cyc + lat);
          expq.push_back(pc_i);
        end
      end
    end
  end

  // Monitor: every decode handshake must match the oldest accepted request
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (instr_valid && instr_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected: got pc %0h expected no instruction", instr_pc);
        end else begin
          e = expq.pop_front();
          chk("mon_pc", instr_pc, e);
          chk("mon_data", instr_data, memfn(e));
        end
      end
    end
  end

  task automatic do_reset(input logic [31:0] sp, input int l);
    @(negedge clk);
    rst = 1'b1;
    flush = 1'b0;
    imem_req_ready = 1'b1;
    start_pc = sp;
    lat = l;
    #3;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_pc_advance", pc_advance, 1'b0);
  endtask

  initial begin
    logic [5:0] rdy_pat;
    int exp_addr5 [6];
    rst = 1'b1; flush = 1'b0; instr_ready = 1'b0; imem_req_ready = 1'b0;
    rdy_pat = 6'b110011;
    exp_addr5 = '{0, 4, 8, 8, 8, 12};
    repeat (2) @(negedge clk);

    // Streaming with 1-cycle memory
    instr_ready = 1'b1;
    do_reset(32'h0, 1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); rst = 1'b0; #3;
      if (i == 0) begin
        chk("t1_rst_data", instr_data, 32'h0);
        chk("t1_rst_pc", instr_pc, 32'h0);
      end
      chk("t1_req_valid", imem_req_valid, 1'b1);
      chk("t1_req_addr", imem_req_addr, 4 * i);
      chk("t1_instr_valid", instr_valid, i >= 2);
      if (i >= 2) chk("t1_instr_pc", instr_pc, 4 * (i - 2));
    end

    // Decode stalled: queue fills to DEPTH, then drains in order
    instr_ready = 1'b0;
    do_reset(32'h0, 1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); rst = 1'b0; instr_ready = (i >= 10); #3;
      if (i < 10) begin
        chk("t2_req_valid", imem_req_valid, i < 4);
        if (i < 4) chk("t2_req_addr", imem_req_addr, 4 * i);
        chk("t2_instr_valid", instr_valid, i >= 2);
      end else if (i == 10) begin
        chk("t2_full_req_valid", imem_req_valid, 1'b0);
        chk("t2_pc0", instr_pc, 32'h0);
      end else if (i == 11) begin
        chk("t2_resume_valid", imem_req_valid, 1'b1);
        chk("t2_resume_addr", imem_req_addr, 32'h10);
        chk("t2_pc4", instr_pc, 32'h4);
      end else begin
        chk("t2_drain_valid", instr_valid, 1'b1);
        chk("t2_drain_pc", instr_pc, 32'h8 + 4 * (i - 12));
      end
    end

    // Flush with 3 requests in flight on a 3-cycle memory
    instr_ready = 1'b1;
    do_reset(32'h0, 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rst = 1'b0; flush = (i == 3); target = 32'h100; #3;
      if (i < 3) chk("t3_req_addr", imem_req_addr, 4 * i);
      if (i == 3) begin
        chk("t3_flush_req_valid", imem_req_valid, 1'b0);
        chk("t3_flush_adv", pc_advance, 1'b0);
      end
      if (i == 4) begin
        chk("t3_new_req_valid", imem_req_valid, 1'b1);
        chk("t3_new_req_addr", imem_req_addr, 32'h100);
      end
      if (i >= 3 && i <= 7) chk("t3_no_stale", instr_valid, 1'b0);
      if (i == 8) begin
        chk("t3_first_valid", instr_valid, 1'b1);
        chk("t3_first_pc", instr_pc, 32'h100);
        chk("t3_first_data", instr_data, memfn(32'h100));
      end
    end

    // Flush coinciding with a response and a decode handshake (2-cycle memory)
    do_reset(32'h0, 2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rst = 1'b0; flush = (i == 4); target = 32'h200; #3;
      if (i == 3) chk("t4_pre_pc", instr_pc, 32'h0);
      if (i == 4) begin
        chk("t4_flush_instr_valid", instr_valid, 1'b0);
        chk("t4_flush_req_valid", imem_req_valid, 1'b0);
        chk("t4_flush_rsp", imem_rsp_valid, 1'b1);
      end
      if (i == 5) chk("t4_new_addr", imem_req_addr, 32'h200);
      if (i >= 5 && i <= 7) chk("t4_no_stale", instr_valid, 1'b0);
      if (i == 8) begin
        chk("t4_first_valid", instr_valid, 1'b1);
        chk("t4_first_pc", instr_pc, 32'h200);
      end
    end
    flush = 1'b0;

    // Memory back-pressure 1,1,0,0,1,1
    do_reset(32'h0, 1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); rst = 1'b0; imem_req_ready = (i < 6) ? rdy_pat[i] : 1'b1; #3;
      if (i < 6) begin
        chk("t5_req_valid", imem_req_valid, 1'b1);
        chk("t5_req_addr", imem_req_addr, exp_addr5[i]);
        chk("t5_pc_advance", pc_advance, rdy_pat[i]);
      end
    end

    // Reset mid-stream with two filled entries
    instr_ready = 1'b0;
    do_reset(32'h0, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst = (i == 3);
      instr_ready = (i >= 4);
      if (i == 3) start_pc = 32'h40;
      #3;
      if (i < 3) chk("t6_req_addr", imem_req_addr, 4 * i);
      if (i == 2) chk("t6_filled_valid", instr_valid, 1'b1);
      if (i == 3) begin
        chk("t6_rst_instr_valid", instr_valid, 1'b0);
        chk("t6_rst_req_valid", imem_req_valid, 1'b0);
      end
      if (i == 4) begin
        chk("t6_post_valid", instr_valid, 1'b0);
        chk("t6_post_pc", instr_pc, 32'h0);
        chk("t6_post_data", instr_data, 32'h0);
        chk("t6_restart_addr", imem_req_addr, 32'h40);
      end
      if (i == 5) chk("t6_post_valid2", instr_valid, 1'b0);
      if (i == 6) begin
        chk("t6_restart_valid", instr_valid, 1'b1);
        chk("t6_restart_pc", instr_pc, 32'h40);
      end
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
